seg_scan_driver: RTL and testbench

Time-multiplexed scan driver for the 8-digit seven-segment display. Accepts a 32-bit value through a valid strobe and formats it into hex digits, with optional signed display and leading-zero blanking. Each scan slot emits one 5-bit digit code and an active-low anode enable. It sits directly upstream of the hex-to-segment decoder and feeds that decoder's 5-bit code input. Code meanings: 0x0–0xF are hex digits, 0x10 is minus/dash, 0x1F is blank (all segments off).

---
 rtl/seg_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg_scan_driver.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit seven-segment display.
// Formats a latched 32-bit value into per-digit 5-bit codes and cycles the anodes.
module seg_scan_driver #(
    parameter int SCAN_PERIOD = 100000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] val_in,
    input  logic        valid_in,
    input  logic        signed_in,
    input  logic        blank_lz_in,
    output logic [4:0]  code_out,
    output logic [7:0]  an_out,
    output logic [2:0]  digit_idx_out
);

    localparam int TW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_PERIOD - 1);

    localparam logic [4:0] CODE_MINUS = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h1F;

    logic [TW-1:0] tick;
    logic [2:0]    idx;
    logic          pending;

    logic [31:0]   shadow_val;
    logic          shadow_signed;
    logic          shadow_blank;

    logic [31:0]   disp_val;
    logic          disp_signed;
    logic          disp_blank;

    logic          tick_wrap;
    logic          frame_end;

    logic          neg;
    logic [31:0]   mag;
    logic [2:0]    msd;
    logic [3:0]    msd_p1;
    logic [3:0]    nib;
    logic [4:0]    code_next;

    assign tick_wrap = (tick == TICK_MAX);
    assign frame_end = tick_wrap && (idx == 3'd7);

    // Digit formatting for the current scan index, from the display registers only.
    always_comb begin
        neg    = disp_signed & disp_val[31];
        mag    = neg ? (~disp_val + 32'd1) : disp_val;
        msd    = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (mag[4*k +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
        msd_p1 = {1'b0, msd} + 4'd1;
        nib    = mag[{idx, 2'b00} +: 4];

        if (neg && (mag[31:28] != 4'h0)) begin
            code_next = CODE_MINUS;
        end else if (!neg) begin
            code_next = (disp_blank && (idx > msd)) ? CODE_BLANK : {1'b0, nib};
        end else if (!disp_blank) begin
            code_next = (idx == 3'd7) ? CODE_MINUS : {1'b0, nib};
        end else if (idx <= msd) begin
            code_next = {1'b0, nib};
        end else if ({1'b0, idx} == msd_p1) begin
            code_next = CODE_MINUS;
        end else begin
            code_next = CODE_BLANK;
        end
    end

    // valid_in is a one-cycle strobe with no back-pressure: every strobe is
    // accepted into the shadow, and the shadow reaches the display only at the
    // end of a full 8-digit frame so a frame never mixes two values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tick          <= '0;
            idx           <= 3'd0;
            pending       <= 1'b0;
            shadow_val    <= 32'd0;
            shadow_signed <= 1'b0;
            shadow_blank  <= 1'b0;
            disp_val      <= 32'd0;
            disp_signed   <= 1'b0;
            disp_blank    <= 1'b0;
            an_out        <= 8'hFF;
            code_out      <= CODE_BLANK;
            digit_idx_out <= 3'd0;
        end else begin
            if (tick_wrap) begin
                tick <= '0;
                idx  <= idx + 3'd1;
            end else begin
                tick <= tick + TW'(1);
            end

            if (frame_end && pending) begin
                disp_val    <= shadow_val;
                disp_signed <= shadow_signed;
                disp_blank  <= shadow_blank;
            end

            if (valid_in) begin
                shadow_val    <= val_in;
                shadow_signed <= signed_in;
                shadow_blank  <= blank_lz_in;
                pending       <= 1'b1;
            end else if (frame_end) begin
                pending       <= 1'b0;
            end

            an_out        <= ~(8'b1 << idx);
            code_out      <= code_next;
            digit_idx_out <= idx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-count reference model compared every cycle,
// plus literal whole-frame expectations for the directed cases.
module tb_seg_scan_driver;

    localparam int P = 4;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] val_in;
    logic        valid_in;
    logic        signed_in;
    logic        blank_lz_in;
    logic [4:0]  code_out;
    logic [7:0]  an_out;
    logic [2:0]  digit_idx_out;

    seg_scan_driver #(.SCAN_PERIOD(P)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .val_in        (val_in),
        .valid_in      (valid_in),
        .signed_in     (signed_in),
        .blank_lz_in   (blank_lz_in),
        .code_out      (code_out),
        .an_out        (an_out),
        .digit_idx_out (digit_idx_out)
    );

    // ---------------- clock ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // ---------------- reference model ----------------
    // Digit k of a value, straight from the display rules.
    function automatic logic [4:0] mdig(input logic [31:0] v, input logic s,
                                        input logic b, input int k);
        logic        ng;
        logic [31:0] mg;
        logic [31:0] t;
        logic [4:0]  nb;
        int          nd;
        ng = s & v[31];
        mg = ng ? (32'd0 - v) : v;
        nb = 5'((mg >> (4 * k)) % 16);
        nd = 1;
        t  = mg >> 4;
        while (t != 32'd0) begin
            nd++;
            t = t >> 4;
        end
        if (ng && mg > 32'h0FFF_FFFF) return 5'h10;
        if (!ng) return (b && k >= nd) ? 5'h1F : nb;
        if (!b) return (k == 7) ? 5'h10 : nb;
        if (k < nd) return nb;
        if (k == nd) return 5'h10;
        return 5'h1F;
    endfunction

    int unsigned m_cyc = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_sv = 32'd0;
    logic        m_ss = 1'b0;
    logic        m_sb = 1'b0;
    logic [31:0] m_dv = 32'd0;
    logic        m_ds = 1'b0;
    logic        m_db = 1'b0;
    logic [7:0]  e_an = 8'hFF;
    logic [4:0]  e_code = 5'h1F;
    logic [2:0]  e_idx = 3'd0;
    logic        e_first = 1'b0;
    logic        m_fs = 1'b0;
    logic        chk_en = 1'b0;

    // Position is cycles since reset release; a frame is 8*P cycles.
    always @(posedge clk_in) begin
        int  d;
        bit  bnd;
        if (rst_in) begin
            m_cyc   <= 0;
            m_pend  <= 1'b0;
            m_sv    <= 32'd0;
            m_ss    <= 1'b0;
            m_sb    <= 1'b0;
            m_dv    <= 32'd0;
            m_ds    <= 1'b0;
            m_db    <= 1'b0;
            e_an    <= 8'hFF;
            e_code  <= 5'h1F;
            e_idx   <= 3'd0;
            e_first <= 1'b0;
            m_fs    <= 1'b0;
            chk_en  <= 1'b1;
        end else begin
            d   = int'((m_cyc / P) % 8);
            bnd = (m_cyc % (8 * P)) == (8 * P - 1);
            e_an    <= ~(8'h1 << d);
            e_code  <= mdig(m_dv, m_ds, m_db, d);
            e_idx   <= 3'(d);
            e_first <= (m_cyc % P) == 0;
            m_fs    <= (m_cyc % (8 * P)) == 0;
            if (bnd && m_pend) begin
                m_dv <= m_sv;
                m_ds <= m_ss;
                m_db <= m_sb;
            end
            if (valid_in) begin
                m_sv   <= val_in;
                m_ss   <= signed_in;
                m_sb   <= blank_lz_in;
                m_pend <= 1'b1;
            end else if (bnd) begin
                m_pend <= 1'b0;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // ---------------- scoreboard / compare ----------------
    int          checks = 0;
    int          errors = 0;
    logic [39:0] lit_tab [0:31];
    int          lit_req = 0;
    int          lit_done = 0;
    logic        lit_on = 1'b0;

    always @(negedge clk_in) begin
        int          n_chk;
        int          n_err;
        bit          start;
        bit          on;
        int          d;
        logic [39:0] lit;
        if (chk_en) begin
            n_chk = 1;
            n_err = 0;
            if (an_out !== e_an || code_out !== e_code || digit_idx_out !== e_idx) begin
                n_err = 1;
                $display("FAIL cycle_cmp t=%0t an=%h want %h code=%h want %h idx=%0d want %0d",
                         $time, an_out, e_an, code_out, e_code, digit_idx_out, e_idx);
            end
            start = !lit_on && (lit_done < lit_req) && m_fs;
            on    = lit_on || start;
            if (on && e_first) begin
                lit   = lit_tab[lit_done];
                d     = int'(e_idx);
                n_chk = n_chk + 1;
                if (code_out !== lit[5*d +: 5] || an_out !== ~(8'h1 << d) ||
                    digit_idx_out !== 3'(d)) begin
                    n_err = n_err + 1;
                    $display("FAIL frame_lit req=%0d digit=%0d code=%h want %h an=%h idx=%0d",
                             lit_done, d, code_out, lit[5*d +: 5], an_out, digit_idx_out);
                end
            end
            if (start) lit_on <= 1'b1;
            if (on && e_first && e_idx == 3'd7) begin
                lit_on   <= 1'b0;
                lit_done <= lit_done + 1;
            end
            checks <= checks + n_chk;
            errors <= errors + n_err;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input logic [31:0] v, input logic s, input logic b);
        val_in      = v;
        signed_in   = s;
        blank_lz_in = b;
        valid_in    = 1'b1;
        @(negedge clk_in);
        valid_in    = 1'b0;
    endtask

    task automatic post(input logic [39:0] l);
        lit_tab[lit_req] = l;
        lit_req = lit_req + 1;
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 20 * P; i++) begin
            @(negedge clk_in);
            if (m_fs) return;
        end
        $display("FAIL wait_fs timeout");
        $fatal(1, "frame start never seen");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 * P; i++) begin
            if (lit_done == lit_req) return;
            @(negedge clk_in);
        end
        $display("FAIL wait_done timeout done=%0d req=%0d", lit_done, lit_req);
        $fatal(1, "frame expectation never completed");
    endtask

    task automatic show(input logic [31:0] v, input logic s, input logic b,
                        input logic [39:0] l);
        wait_fs();
        strobe(v, s, b);
        post(l);
        wait_done();
    endtask

    // Literal pins on the model's formatter, run before any DUT activity.
    task automatic pin_model();
        logic [4:0] got [0:7];
        logic [4:0] want [0:7];
        got[0] = mdig(32'hFFFFFF85, 1'b1, 1'b1, 0);  want[0] = 5'h0B;
        got[1] = mdig(32'hFFFFFF85, 1'b1, 1'b1, 2);  want[1] = 5'h10;
        got[2] = mdig(32'hFFFFFF85, 1'b1, 1'b1, 3);  want[2] = 5'h1F;
        got[3] = mdig(32'hFFFFFF85, 1'b1, 1'b0, 7);  want[3] = 5'h10;
        got[4] = mdig(32'h80000000, 1'b1, 1'b0, 3);  want[4] = 5'h10;
        got[5] = mdig(32'h00000000, 1'b0, 1'b1, 0);  want[5] = 5'h00;
        got[6] = mdig(32'h000000A5, 1'b0, 1'b1, 1);  want[6] = 5'h0A;
        got[7] = mdig(32'h1234ABCD, 1'b0, 1'b0, 4);  want[7] = 5'h04;
        for (int i = 0; i < 8; i++) begin
            if (got[i] !== want[i]) begin
                $display("FAIL model_pin %0d got %h want %h", i, got[i], want[i]);
                errors = errors + 1;
            end
            checks = checks + 1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_in      = 1'b1;
        valid_in    = 1'b0;
        val_in      = 32'd0;
        signed_in   = 1'b0;
        blank_lz_in = 1'b0;
        pin_model();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        show(32'h1234ABCD, 1'b0, 1'b0,
             {5'h1, 5'h2, 5'h3, 5'h4, 5'hA, 5'hB, 5'hC, 5'hD});
        show(32'h000000A5, 1'b0, 1'b1,
             {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'hA, 5'h5});
        show(32'h00000000, 1'b0, 1'b1,
             {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h0});
        show(32'hFFFFFF85, 1'b1, 1'b1,
             {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h10, 5'h7, 5'hB});
        show(32'hFFFFFF85, 1'b1, 1'b0,
             {5'h10, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h7, 5'hB});
        show(32'h80000000, 1'b1, 1'b0, {8{5'h10}});
        show(32'h7FFFFFFF, 1'b1, 1'b1,
             {5'h7, 5'hF, 5'hF, 5'hF, 5'hF, 5'hF, 5'hF, 5'hF});

        // Tear-free: strobes mid-frame must not disturb the frame in flight.
        show(32'h11111111, 1'b0, 1'b0, {8{5'h1}});
        post({8{5'h1}});
        wait_fs();
        repeat (2 * P) @(negedge clk_in);
        strobe(32'h22222222, 1'b0, 1'b0);
        repeat (3 * P - 1) @(negedge clk_in);
        strobe(32'h33333333, 1'b0, 1'b0);
        post({8{5'h3}});
        wait_done();

        // Strobe landing on the frame-boundary cycle shows one frame later.
        wait_fs();
        strobe(32'h44444444, 1'b0, 1'b0);
        repeat (8 * P - 3) @(negedge clk_in);
        strobe(32'h55555555, 1'b0, 1'b0);
        post({8{5'h4}});
        post({8{5'h5}});
        wait_done();

        // Reset mid-digit discards the pending load.
        wait_fs();
        strobe(32'h66666666, 1'b0, 1'b0);
        repeat (4 * P) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        post({8{5'h0}});
        wait_done();

        // Randomized loads and occasional resets, checked by the model.
        repeat (3000) begin
            logic [31:0] v;
            case ($urandom_range(0, 5))
                0:       v = $urandom;
                1:       v = 32'($urandom_range(0, 255));
                2:       v = 32'd0 - 32'($urandom_range(1, 65535));
                3:       v = 32'h80000000;
                4:       v = 32'd0;
                default: v = $urandom & 32'h0FFF_F0F0;
            endcase
            val_in      = v;
            signed_in   = 1'($urandom_range(0, 1));
            blank_lz_in = 1'($urandom_range(0, 1));
            valid_in    = ($urandom_range(0, 19) == 0);
            rst_in      = ($urandom_range(0, 399) == 0);
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        rst_in   = 1'b0;
        repeat (2) @(negedge clk_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
